// File: rtl/lsu_mem_ctrl.sv
// lsu_mem_ctrl: RV32I load/store front-end to a byte-masked RAM with 1-cycle registered read
module lsu_mem_ctrl #(
  parameter int          DEPTH     = 512,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          ADDR_W    = $clog2(DEPTH*4)
) (
  input  logic              clk,
  input  logic              rst_n_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_we_i,
  input  logic [2:0]        req_funct3_i,
  input  logic [31:0]       req_addr_i,
  input  logic [31:0]       req_wdata_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [31:0]       rsp_rdata_o,
  output logic              rsp_err_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [31:0]       mem_wr_data_o,
  output logic [3:0]        mem_bytemask_o,
  output logic              mem_write_en_o,
  output logic              mem_read_en_o,
  input  logic [31:0]       mem_rd_data_i
);
  typedef enum logic [1:0] {IDLE, LOAD_DATA, RESP} state_t;
  state_t state, state_n;
  logic [1:0] off, off_n;
  logic [2:0] f3, f3_n;
  logic [31:0] rdata_n;
  logic err_n, accept, legal, misal, in_range, fault;
  logic [32:0] rel_addr;
  logic [7:0] lb;
  logic [15:0] lh;
  assign req_ready_o = state == IDLE;
  assign rsp_valid_o = state == RESP;
  // Below-base addresses wrap to a huge offset, so one unsigned compare covers both bounds
  always_comb begin
    accept = req_valid_i & req_ready_o;
    legal = req_we_i ? ~req_funct3_i[2] & (req_funct3_i[1:0] != 2'b11)
                     : (req_funct3_i[1:0] != 2'b11) & ~(req_funct3_i[2] & req_funct3_i[1]);
    misal = (req_funct3_i[1:0] == 2'b01 & req_addr_i[0]) | (req_funct3_i[1:0] == 2'b10 & |req_addr_i[1:0]);
    rel_addr = {1'b0, req_addr_i} - {1'b0, BASE_ADDR};
    in_range = rel_addr < 33'(DEPTH) * 33'd4;
    fault = ~legal | misal | ~in_range;
    mem_addr_o = rel_addr[ADDR_W-1:0];
    mem_wr_data_o = req_funct3_i[1:0] == 2'b00 ? {4{req_wdata_i[7:0]}} :
                    req_funct3_i[1:0] == 2'b01 ? {2{req_wdata_i[15:0]}} : req_wdata_i;
    mem_bytemask_o = ~req_we_i || req_funct3_i[1:0] == 2'b10 ? 4'b1111 :
                     req_funct3_i[1:0] == 2'b01 ? (req_addr_i[1] ? 4'b1100 : 4'b0011) :
                     4'b0001 << req_addr_i[1:0];
    mem_write_en_o = accept & ~fault & req_we_i;
    mem_read_en_o = accept & ~fault & ~req_we_i;
    lb = mem_rd_data_i[{off, 3'b000} +: 8];
    lh = off[1] ? mem_rd_data_i[31:16] : mem_rd_data_i[15:0];
    state_n = state;
    off_n = off;
    f3_n = f3;
    rdata_n = rsp_rdata_o;
    err_n = rsp_err_o;
    if (accept) begin
      state_n = fault | req_we_i ? RESP : LOAD_DATA;
      off_n = req_addr_i[1:0];
      f3_n = req_funct3_i;
      rdata_n = '0;
      err_n = fault;
    end else if (state == LOAD_DATA) begin
      state_n = RESP;
      rdata_n = f3[1] ? mem_rd_data_i :
                f3[0] ? {{16{~f3[2] & lh[15]}}, lh} : {{24{~f3[2] & lb[7]}}, lb};
    end else if (state == RESP && rsp_ready_i) begin
      state_n = IDLE;
      rdata_n = '0;
      err_n = 1'b0;
    end
  end
  always_ff @(posedge clk or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state <= IDLE;
      off <= '0;
      f3 <= '0;
      rsp_rdata_o <= '0;
      rsp_err_o <= 1'b0;
    end else begin
      state <= state_n;
      off <= off_n;
      f3 <= f3_n;
      rsp_rdata_o <= rdata_n;
      rsp_err_o <= err_n;
    end
  end
endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// tb_lsu_mem_ctrl: directed checks of lsu_mem_ctrl against a behavioural byte-masked RAM
module tb_lsu_mem_ctrl;
  logic clk = 1'b0;
  logic rst_n_i, req_valid_i, req_ready_o, req_we_i, rsp_valid_o, rsp_ready_i, rsp_err_o;
  logic mem_write_en_o, mem_read_en_o;
  logic [2:0] req_funct3_i;
  logic [31:0] req_addr_i, req_wdata_i, rsp_rdata_o, mem_wr_data_o, mem_rd_data_i;
  logic [10:0] mem_addr_o;
  logic [3:0] mem_bytemask_o;
  logic [31:0] ram [512];
  int vectors = 0, miscompares = 0;

  always #5 clk = ~clk;

  lsu_mem_ctrl dut (
    .clk(clk), .rst_n_i(rst_n_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
    .req_funct3_i(req_funct3_i), .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_rdata_o(rsp_rdata_o),
    .rsp_err_o(rsp_err_o), .mem_addr_o(mem_addr_o), .mem_wr_data_o(mem_wr_data_o),
    .mem_bytemask_o(mem_bytemask_o), .mem_write_en_o(mem_write_en_o),
    .mem_read_en_o(mem_read_en_o), .mem_rd_data_i(mem_rd_data_i)
  );

  always @(posedge clk) begin
    if (mem_write_en_o)
      for (int i = 0; i < 4; i++)
        if (mem_bytemask_o[i]) ram[mem_addr_o[10:2]][8*i +: 8] <= mem_wr_data_o[8*i +: 8];
    if (mem_read_en_o) mem_rd_data_i <= ram[mem_addr_o[10:2]];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Presents a request at a negedge, checks the accept-cycle strobes, then drops valid after the edge
  task automatic do_req(input string tag, input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, input logic exp_wr, input logic exp_rd,
                        input logic [3:0] exp_mask, input logic [31:0] exp_wdata);
    @(negedge clk);
    req_valid_i = 1'b1; req_we_i = we; req_funct3_i = f3; req_addr_i = addr; req_wdata_i = wd;
    #1;
    chk({tag, " ready"}, 32'(req_ready_o), 32'd1);
    chk({tag, " wr_en"}, 32'(mem_write_en_o), 32'(exp_wr));
    chk({tag, " rd_en"}, 32'(mem_read_en_o), 32'(exp_rd));
    if (exp_wr | exp_rd) begin
      chk({tag, " mask"}, 32'(mem_bytemask_o), 32'(exp_mask));
      chk({tag, " addr"}, 32'(mem_addr_o), addr & 32'h7FF);
    end
    if (exp_wr) chk({tag, " wdata"}, mem_wr_data_o, exp_wdata);
    @(posedge clk);
    #1 req_valid_i = 1'b0;
    chk({tag, " strobes off"}, {30'd0, mem_write_en_o, mem_read_en_o}, 32'd0);
  endtask

  task automatic do_rsp(input string tag, input int lat, input logic [31:0] exp_data, input logic exp_err);
    @(negedge clk);
    if (lat == 2) begin
      chk({tag, " early valid"}, 32'(rsp_valid_o), 32'd0);
      @(negedge clk);
    end
    chk({tag, " valid"}, 32'(rsp_valid_o), 32'd1);
    chk({tag, " rdata"}, rsp_rdata_o, exp_data);
    chk({tag, " err"}, 32'(rsp_err_o), 32'(exp_err));
    rsp_ready_i = 1'b1;
    @(negedge clk);
    rsp_ready_i = 1'b0;
    chk({tag, " valid clr"}, 32'(rsp_valid_o), 32'd0);
    chk({tag, " rdata clr"}, rsp_rdata_o, 32'd0);
    chk({tag, " err clr"}, 32'(rsp_err_o), 32'd0);
    chk({tag, " idle"}, 32'(req_ready_o), 32'd1);
  endtask

  initial begin
    for (int i = 0; i < 512; i++) ram[i] = '0;
    rst_n_i = 1'b0; req_valid_i = 1'b0; req_we_i = 1'b0; req_funct3_i = '0;
    req_addr_i = '0; req_wdata_i = '0; rsp_ready_i = 1'b0;
    #1;
    chk("rst valid", 32'(rsp_valid_o), 32'd0);
    chk("rst rdata", rsp_rdata_o, 32'd0);
    chk("rst err", 32'(rsp_err_o), 32'd0);
    chk("rst ready", 32'(req_ready_o), 32'd1);
    @(negedge clk);
    @(negedge clk);
    rst_n_i = 1'b1;

    do_req("sw", 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 1'b1, 1'b0, 4'b1111, 32'hDEADBEEF);
    do_rsp("sw", 1, 32'h0, 1'b0);
    do_req("lw", 1'b0, 3'b010, 32'h10, 32'h0, 1'b0, 1'b1, 4'b1111, 32'h0);
    do_rsp("lw", 2, 32'hDEADBEEF, 1'b0);

    do_req("sb", 1'b1, 3'b000, 32'h13, 32'h000000A5, 1'b1, 1'b0, 4'b1000, 32'hA5A5A5A5);
    do_rsp("sb", 1, 32'h0, 1'b0);
    do_req("lb", 1'b0, 3'b000, 32'h13, 32'h0, 1'b0, 1'b1, 4'b1111, 32'h0);
    do_rsp("lb", 2, 32'hFFFFFFA5, 1'b0);
    do_req("lbu", 1'b0, 3'b100, 32'h13, 32'h0, 1'b0, 1'b1, 4'b1111, 32'h0);
    do_rsp("lbu", 2, 32'h000000A5, 1'b0);
    do_req("lw2", 1'b0, 3'b010, 32'h10, 32'h0, 1'b0, 1'b1, 4'b1111, 32'h0);
    do_rsp("lw2", 2, 32'hA5ADBEEF, 1'b0);

    do_req("sh", 1'b1, 3'b001, 32'h12, 32'h00008001, 1'b1, 1'b0, 4'b1100, 32'h80018001);
    do_rsp("sh", 1, 32'h0, 1'b0);
    do_req("lh", 1'b0, 3'b001, 32'h12, 32'h0, 1'b0, 1'b1, 4'b1111, 32'h0);
    do_rsp("lh", 2, 32'hFFFF8001, 1'b0);
    do_req("lhu", 1'b0, 3'b101, 32'h12, 32'h0, 1'b0, 1'b1, 4'b1111, 32'h0);
    do_rsp("lhu", 2, 32'h00008001, 1'b0);
    do_req("lb0", 1'b0, 3'b000, 32'h10, 32'h0, 1'b0, 1'b1, 4'b1111, 32'h0);
    do_rsp("lb0", 2, 32'hFFFFFFEF, 1'b0);

    do_req("f lw11", 1'b0, 3'b010, 32'h11, 32'h0, 1'b0, 1'b0, 4'b0, 32'h0);
    do_rsp("f lw11", 1, 32'h0, 1'b1);
    do_req("f lh13", 1'b0, 3'b001, 32'h13, 32'h0, 1'b0, 1'b0, 4'b0, 32'h0);
    do_rsp("f lh13", 1, 32'h0, 1'b1);
    do_req("f sw800", 1'b1, 3'b010, 32'h800, 32'h12345678, 1'b0, 1'b0, 4'b0, 32'h0);
    do_rsp("f sw800", 1, 32'h0, 1'b1);
    do_req("f ld011", 1'b0, 3'b011, 32'h10, 32'h0, 1'b0, 1'b0, 4'b0, 32'h0);
    do_rsp("f ld011", 1, 32'h0, 1'b1);
    do_req("f st100", 1'b1, 3'b100, 32'h10, 32'h0, 1'b0, 1'b0, 4'b0, 32'h0);
    do_rsp("f st100", 1, 32'h0, 1'b1);
    do_req("lw chk", 1'b0, 3'b010, 32'h10, 32'h0, 1'b0, 1'b1, 4'b1111, 32'h0);
    do_rsp("lw chk", 2, 32'h8001BEEF, 1'b0);

    do_req("bp lw", 1'b0, 3'b010, 32'h10, 32'h0, 1'b0, 1'b1, 4'b1111, 32'h0);
    @(negedge clk);
    req_valid_i = 1'b1; req_we_i = 1'b0; req_funct3_i = 3'b100; req_addr_i = 32'h12; req_wdata_i = '0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp valid", 32'(rsp_valid_o), 32'd1);
      chk("bp rdata", rsp_rdata_o, 32'h8001BEEF);
      chk("bp ready", 32'(req_ready_o), 32'd0);
      chk("bp rd_en", 32'(mem_read_en_o), 32'd0);
    end
    rsp_ready_i = 1'b1;
    @(negedge clk);
    rsp_ready_i = 1'b0;
    chk("b2b valid", 32'(rsp_valid_o), 32'd0);
    chk("b2b ready", 32'(req_ready_o), 32'd1);
    chk("b2b rd_en", 32'(mem_read_en_o), 32'd1);
    @(posedge clk);
    #1 req_valid_i = 1'b0;
    do_rsp("b2b lbu", 2, 32'h00000001, 1'b0);

    do_req("rst lw", 1'b0, 3'b010, 32'h10, 32'h0, 1'b0, 1'b1, 4'b1111, 32'h0);
    @(negedge clk);
    rst_n_i = 1'b0;
    #1;
    chk("rst ld valid", 32'(rsp_valid_o), 32'd0);
    chk("rst ld rdata", rsp_rdata_o, 32'd0);
    @(negedge clk);
    rst_n_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("post rst valid", 32'(rsp_valid_o), 32'd0);
      chk("post rst ready", 32'(req_ready_o), 32'd1);
    end
    do_req("post rst lhu", 1'b0, 3'b101, 32'h10, 32'h0, 1'b0, 1'b1, 4'b1111, 32'h0);
    do_rsp("post rst lhu", 2, 32'h0000BEEF, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
